uart_byte_receiver: RTL

//   8N1 UART receive front-end. Serialises nothing; deserialises UART_RX into bytes

---
 rtl/uart_byte_receiver.sv | 135 +++++++++++++
 1 files changed

// File: rtl/uart_byte_receiver.sv
// 8N1 UART receiver with 2-FF synchroniser and 3-sample majority voting.
// Emits one-cycle valid / frame_err pulses; data holds the last good byte.
module uart_byte_receiver #(
   parameter int CLK_PER_BIT = 868
) (
   input  logic       CLK,
   input  logic       INITIALIZE,
   input  logic       UART_RX,
   output logic [7:0] data,
   output logic       valid,
   output logic       frame_err,
   output logic       busy
);

   localparam int MID = CLK_PER_BIT / 2;
   localparam int CW  = $clog2(CLK_PER_BIT);

   localparam logic [CW-1:0] C_S0   = CW'(MID - 1);
   localparam logic [CW-1:0] C_S1   = CW'(MID);
   localparam logic [CW-1:0] C_DEC  = CW'(MID + 1);
   localparam logic [CW-1:0] C_LAST = CW'(CLK_PER_BIT - 1);

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      STOP,
      BREAK
   } state_t;

   state_t r_state;
   state_t w_next;

   logic          r_sync1;
   logic          r_rx_s;
   logic          r_rx_prev;
   logic [CW-1:0] r_cnt;
   logic [2:0]    r_bit_idx;
   logic [7:0]    r_shift;
   logic          r_smp0;
   logic          r_smp1;

   logic w_fall;
   logic w_dec;
   logic w_bit;
   logic w_valid_nxt;
   logic w_ferr_nxt;

   assign w_fall = (r_state == IDLE) && !r_rx_s && r_rx_prev;
   assign w_dec  = (r_cnt == C_DEC);
   // Third sample is the live synchronised line on the decision cycle.
   assign w_bit  = (r_smp0 & r_smp1) | (r_smp0 & r_rx_s) | (r_smp1 & r_rx_s);
   assign busy   = (r_state != IDLE);

   always_ff @(posedge CLK) begin
      if (INITIALIZE) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next      = r_state;
      w_valid_nxt = 1'b0;
      w_ferr_nxt  = 1'b0;
      unique case (r_state)
         IDLE: begin
            if (w_fall) w_next = START;
         end
         START: begin
            if (w_dec) w_next = w_bit ? IDLE : DATA;
         end
         DATA: begin
            if (w_dec && (r_bit_idx == 3'd7)) w_next = STOP;
         end
         STOP: begin
            if (w_dec) begin
               if (w_bit) begin
                  w_next      = IDLE;
                  w_valid_nxt = 1'b1;
               end else begin
                  w_next     = BREAK;
                  w_ferr_nxt = 1'b1;
               end
            end
         end
         BREAK: begin
            if (r_rx_s) w_next = IDLE;
         end
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (INITIALIZE) begin
         r_sync1   <= 1'b1;
         r_rx_s    <= 1'b1;
         r_rx_prev <= 1'b1;
         r_cnt     <= '0;
         r_bit_idx <= 3'd0;
         r_shift   <= 8'h00;
         r_smp0    <= 1'b1;
         r_smp1    <= 1'b1;
         data      <= 8'h00;
         valid     <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         r_sync1   <= UART_RX;
         r_rx_s    <= r_sync1;
         r_rx_prev <= r_rx_s;
         valid     <= w_valid_nxt;
         frame_err <= w_ferr_nxt;
         if (w_valid_nxt) data <= r_shift;

         if (r_state == IDLE) begin
            r_cnt <= w_fall ? CW'(1) : '0;
         end else if (r_cnt == C_LAST) begin
            r_cnt <= '0;
         end else begin
            r_cnt <= r_cnt + 1'b1;
         end

         if (r_cnt == C_S0) r_smp0 <= r_rx_s;
         if (r_cnt == C_S1) r_smp1 <= r_rx_s;

         if ((r_state == START) && w_dec) r_bit_idx <= 3'd0;
         if ((r_state == DATA) && w_dec) begin
            r_shift   <= {w_bit, r_shift[7:1]};
            r_bit_idx <= r_bit_idx + 3'd1;
         end
      end
   end

endmodule
